// File: rtl/console_mmio.sv
// Console MMIO shim between the cpu memory port and the RAM model: console-address
// writes go to a byte FIFO drained to a character sink; everything else passes through.
module console_mmio #(
  parameter logic [63:0] CONSOLE_ADDR = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          DEPTH        = 16,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      mem_raddr,
  output logic [63:0]      mem_rdata,
  input  logic             mem_wen,
  input  logic [63:0]      mem_waddr,
  input  logic [63:0]      mem_wdata,
  input  logic             done,
  output logic [63:0]      ram_raddr,
  input  logic [63:0]      ram_rdata,
  output logic             ram_wen,
  output logic [63:0]      ram_waddr,
  output logic [63:0]      ram_wdata,
  output logic             char_valid,
  output logic [7:0]       char_data,
  input  logic             char_ready,
  output logic             halted,
  output logic             overflow,
  output logic [CNT_W-1:0] char_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        fifo_mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              overflow_q;
  logic [CNT_W-1:0]  char_count_q, drop_count_q;

  logic cons_wr, full, push, pop, drop, accepting;

  // Pass-through paths: purely combinational, no added latency.
  assign cons_wr   = mem_wen && (mem_waddr == CONSOLE_ADDR);
  assign ram_raddr = mem_raddr;
  assign mem_rdata = ram_rdata;
  assign ram_waddr = mem_waddr;
  assign ram_wdata = mem_wdata;
  assign ram_wen   = mem_wen && !cons_wr;

  // Sink handshake: a byte transfers on a rising edge where char_valid && char_ready;
  // char_valid/char_data come from registered state only and hold while the sink stalls.
  assign full      = (count_q == OCC_FULL);
  assign pop       = char_valid && char_ready;
  assign accepting = cons_wr && (state_q != S_HALTED);
  assign push      = accepting && (!full || pop);
  assign drop      = accepting && full && !pop;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // FSM: next state; DRAIN still takes pushes since done may coincide with the last write
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:    if (done) state_d = S_DRAIN;
      S_DRAIN:  if (count_q == '0 && !push) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    halted     = (state_q == S_HALTED);
    char_valid = (count_q != '0);
    char_data  = fifo_mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      char_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + AW'(1);
        char_count_q <= char_count_q + CNT_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q   <= 1'b1;
        drop_count_q <= drop_count_q + CNT_W'(1);
      end
    end
  end

  assign overflow   = overflow_q;
  assign char_count = char_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_console_mmio.sv
// Directed bench for console_mmio: pass-through, streaming, overflow, drain-on-done, reset.
module tb_console_mmio;

  localparam logic [63:0] CONS = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic        mem_wen, done;
  logic [63:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata;
  logic        ram_wen;
  logic        char_valid, char_ready, halted, overflow;
  logic [7:0]  char_data;
  logic [31:0] char_count, drop_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  console_mmio dut (
    .clk(clk), .rst(rst),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .done(done),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_wen(ram_wen),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .halted(halted), .overflow(overflow),
    .char_count(char_count), .drop_count(drop_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_wen   = 1'b0;
    mem_waddr = 64'h0;
    mem_wdata = 64'h0;
    done      = 1'b0;
  endtask

  task automatic cons_write(input logic [7:0] b, input logic expect_push);
    mem_wen   = 1'b1;
    mem_waddr = CONS;
    mem_wdata = {56'hA5A5_0000_1111_22, b};
    if (expect_push) exp_q.push_back(b);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (char_valid && n < 100) begin
      next_cycle();
      n++;
    end
    chk(tag, 64'(n < 100), 64'd1);
  endtask

  // scoreboard: sink side, sampled at negedge while inputs are stable
  always @(negedge clk) begin
    if (!rst && char_valid && char_ready) begin
      if (exp_q.size() == 0) chk("sink_unexpected", {56'h0, char_data}, 64'hFFFF);
      else chk("sink_byte", {56'h0, char_data}, {56'h0, exp_q.pop_front()});
    end
  end

  initial begin
    rst = 1'b1; idle(); char_ready = 1'b0;
    mem_raddr = 64'h0; ram_rdata = 64'h0;
    next_cycle(); next_cycle();
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(char_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_char_count", 64'(char_count), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);

    // pass-through
    mem_wen = 1'b1; mem_waddr = 64'h1000; mem_wdata = 64'hDEAD;
    mem_raddr = 64'h1000; ram_rdata = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("pt_ram_wen", 64'(ram_wen), 64'd1);
    chk("pt_ram_waddr", ram_waddr, 64'h1000);
    chk("pt_ram_wdata", ram_wdata, 64'hDEAD);
    chk("pt_ram_raddr", ram_raddr, 64'h1000);
    chk("pt_mem_rdata", mem_rdata, 64'h1234_5678_9ABC_DEF0);
    next_cycle();
    mem_waddr = 64'hFFFF_FFFF_FFFF_FFFE; mem_wdata = 64'h77;
    #1;
    chk("near_miss_ram_wen", 64'(ram_wen), 64'd1);
    next_cycle();
    idle();
    #1;
    chk("pt_fifo_empty", 64'(char_valid), 64'd0);

    // alphabet stream with sink always ready
    char_ready = 1'b1;
    for (int i = 0; i < 26; i++) begin
      cons_write(8'h41 + 8'(i), 1'b1);
      #1;
      chk("alpha_ram_wen", 64'(ram_wen), 64'd0);
      chk("alpha_valid", 64'(char_valid), 64'(i > 0));
      if (i > 0) chk("alpha_head", {56'h0, char_data}, 64'h40 + 64'(i));
      next_cycle();
    end
    idle();
    wait_empty("alpha_drain_timeout");
    chk("alpha_char_count", 64'(char_count), 64'd26);

    // backpressure and overflow
    char_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cons_write(8'h30 + 8'(i), i < 16);
      next_cycle();
    end
    idle();
    #1;
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop_count", 64'(drop_count), 64'd4);
    chk("ovf_head", {56'h0, char_data}, 64'h30);
    next_cycle(); next_cycle();
    chk("ovf_head_hold", {56'h0, char_data}, 64'h30);
    chk("ovf_valid_hold", 64'(char_valid), 64'd1);

    // full with simultaneous pop: accepted, then still full
    char_ready = 1'b1;
    cons_write(8'h7A, 1'b1);
    next_cycle();
    chk("fullpop_no_drop", 64'(drop_count), 64'd4);
    char_ready = 1'b0;
    cons_write(8'h7B, 1'b0);
    next_cycle();
    idle();
    chk("fullpop_still_full", 64'(drop_count), 64'd5);
    char_ready = 1'b1;
    wait_empty("ovf_drain_timeout");
    chk("ovf_char_count", 64'(char_count), 64'd43);

    // drain on done, done coinciding with the last write
    char_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cons_write(8'h61 + 8'(i), 1'b1);
      done = (i == 4);
      next_cycle();
    end
    idle();
    repeat (3) begin
      next_cycle();
      chk("drain_not_halted", 64'(halted), 64'd0);
    end
    char_ready = 1'b1;
    repeat (5) next_cycle();
    chk("drain_empty", 64'(char_valid), 64'd0);
    chk("drain_halted_late", 64'(halted), 64'd0);
    next_cycle();
    chk("drain_halted", 64'(halted), 64'd1);
    cons_write(8'h99, 1'b0);
    #1;
    chk("halted_cons_no_ram", 64'(ram_wen), 64'd0);
    next_cycle();
    idle();
    chk("halted_ignore_valid", 64'(char_valid), 64'd0);
    chk("halted_ignore_drop", 64'(drop_count), 64'd5);
    chk("halted_char_count", 64'(char_count), 64'd48);

    // reset out of HALTED, then reset mid-drain
    rst = 1'b1; next_cycle(); rst = 1'b0;
    chk("rst2_halted", 64'(halted), 64'd0);
    chk("rst2_drop_count", 64'(drop_count), 64'd0);
    char_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cons_write(8'h10 + 8'(i), 1'b0);
      next_cycle();
    end
    idle();
    done = 1'b1;
    next_cycle();
    done = 1'b0;
    next_cycle();
    chk("mid_drain_valid", 64'(char_valid), 64'd1);
    chk("mid_drain_halted", 64'(halted), 64'd0);
    rst = 1'b1; next_cycle(); rst = 1'b0;
    chk("rst3_valid", 64'(char_valid), 64'd0);
    chk("rst3_halted", 64'(halted), 64'd0);
    chk("rst3_char_count", 64'(char_count), 64'd0);
    chk("rst3_overflow", 64'(overflow), 64'd0);
    char_ready = 1'b1;
    cons_write(8'h5A, 1'b1);
    next_cycle();
    idle();
    chk("post_rst_valid", 64'(char_valid), 64'd1);
    chk("post_rst_data", {56'h0, char_data}, 64'h5A);
    next_cycle();
    chk("post_rst_char_count", 64'(char_count), 64'd1);
    done = 1'b1;
    next_cycle();
    done = 1'b0;
    next_cycle(); next_cycle();
    chk("post_rst_halted", 64'(halted), 64'd1);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/console_mmio.md
Name: console_mmio

Overview:
- Sits directly downstream of the cpu memory port in the testbench, between the cpu and the backing RAM model.
- Intercepts writes to the console address (all-ones). Buffers their low byte in a FIFO and drains it to a character sink with a valid/ready handshake.
- All other reads and writes pass through to RAM.
- On the cpu `done` pulse, the FIFO drains fully before `halted` is raised, so the bench never truncates output.

Parameters:
- CONSOLE_ADDR, 64'hFFFF_FFFF_FFFF_FFFF, write address treated as the console.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_W, 32, width of the char and drop counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_raddr  in  64  cpu read address.
- mem_rdata  out  64  read data returned to cpu.
- mem_wen  in  1  cpu write enable.
- mem_waddr  in  64  cpu write address.
- mem_wdata  in  64  cpu write data.
- done  in  1  cpu completion flag.
- ram_raddr  out  64  read address to RAM model.
- ram_rdata  in  64  RAM read data.
- ram_wen  out  1  RAM write enable.
- ram_waddr  out  64  RAM write address.
- ram_wdata  out  64  RAM write data.
- char_valid  out  1  FIFO head valid.
- char_data  out  8  FIFO head byte.
- char_ready  in  1  sink accepts head this cycle.
- halted  out  1  done seen and FIFO empty; sticky.
- overflow  out  1  sticky; a console write was dropped because the FIFO was full.
- char_count  out  CNT_W  bytes popped to the sink; wraps.
- drop_count  out  CNT_W  console writes dropped; wraps.

Behaviour:
- Reset (sync, rst=1 at edge) clears:
  - FIFO pointers and occupancy to 0
  - state to RUN
  - halted, overflow, char_count and drop_count to 0
- Consequently char_valid=0 after reset.
- Address decode:
  - cons_wr = mem_wen && (mem_waddr == CONSOLE_ADDR).
  - Full 64-bit compare; no partial decode.
- Pass-through paths are combinational, with no added latency:
  - ram_raddr = mem_raddr.
  - ram_waddr = mem_waddr and ram_wdata = mem_wdata.
  - ram_wen = mem_wen && !cons_wr.
  - mem_rdata = ram_rdata.
- Push rules:
  - Push occurs when cons_wr and state != HALTED and (!full || pop).
  - The pushed entry is mem_wdata[7:0]; the upper bits are ignored.
  - Simultaneous push and pop when full is allowed; occupancy stays at DEPTH.
  - Push and pop on the same cycle at any occupancy leaves occupancy unchanged.
- Drop rules:
  - A drop occurs when cons_wr and state != HALTED and full and !pop.
  - On a drop, drop_count increments and overflow is set (sticky until reset).
  - cons_wr while HALTED is ignored: no push, no drop count.
- Pop and output:
  - pop = char_valid && char_ready.
  - char_valid = (occupancy != 0); char_data = head entry.
  - Both are registered-state driven, so a pushed byte is visible no earlier than the next cycle (1-cycle latency).
  - char_data must hold stable while char_valid=1 and char_ready=0.
  - char_count increments by 1 per pop.
- Counters wrap modulo 2^CNT_W.
- FIFO pointers are log2(DEPTH) bits with natural wrap. Occupancy is log2(DEPTH)+1 bits, range 0..DEPTH.
- FSM, evaluated at each rising edge:
  - RUN: if done=1, go to DRAIN.
  - DRAIN: pushes are still accepted, because done may coincide with the final console write. If occupancy==0 and no push this cycle, go to HALTED.
  - HALTED: terminal until reset; halted=1.
- halted is a registered output, asserted in the cycle after the transition edge.
- done falling after being seen has no effect.
- If done and a console write arrive in the same cycle in RUN, the byte is pushed and the state moves to DRAIN.
- Reset asserted mid-drain or in HALTED returns to RUN with the FIFO empty. Buffered bytes are discarded and not counted.

Test Plan:
- Pass-through: write addr 0x1000, data 0xDEAD, mem_wen=1 -> ram_wen=1, ram_waddr=0x1000 in the same cycle, FIFO empty. A read of 0x1000 returns ram_rdata unchanged.
- Alphabet stream: console writes 0x41..0x5A on consecutive cycles, char_ready=1 -> sink sees 26 bytes 'A'..'Z' in order, each 1 cycle after its push; char_count=26; ram_wen never 1.
- Backpressure/overflow: char_ready=0, 20 console writes 0x30..0x43, DEPTH=16 -> first 16 buffered, overflow=1, drop_count=4. Then char_ready=1 -> bytes 0x30..0x3F emitted, char_count=16.
- Full with simultaneous pop: FIFO full, char_ready=1, one console write 0x7A -> no drop, occupancy stays 16, 0x7A emitted last.
- Drain on done: 5 bytes buffered, char_ready=0, done=1 -> halted stays 0. Release char_ready -> halted=1 the cycle after the 5th pop. A later console write is ignored and drop_count is unchanged.
- Reset mid-drain: 3 bytes buffered in DRAIN, rst=1 for one cycle -> char_valid=0, halted=0, char_count=0, overflow=0; the next console write is emitted normally.
